nco_voice_acc: RTL and testbench
================================

Name: nco_voice_acc

Overview:
- Time-multiplexed multi-voice phase accumulator.
- Sits directly downstream of the step-size ROM: drives the ROM address and clock enable, consumes its 16-bit step, and advances one phase accumulator per voice on every sample tick.
- Holds a per-voice note/gate table written by the note-assignment logic.
- Outputs a serial stream of truncated phases, one per voice, to the waveform lookup stage.

Parameters:
- VOICES, 8, number of voices; power of two, 2..32.
- VIDX_W, 3, voice index width, equal to log2(VOICES).
- ACC_W, 24, phase accumulator width; must be at least 17.
- OUT_W, 16, phase output width; the top OUT_W bits of the accumulator; OUT_W is at most ACC_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle strobe that starts a sweep over all voices
- note_we  in  1  note table write enable
- note_voice  in  VIDX_W  voice to write
- note_num  in  7  MIDI note number
- note_gate  in  1  1 = voice sounding, 0 = voice released
- rom_ce  out  1  step ROM clock enable
- rom_a  out  7  step ROM address
- rom_d  in  16  step ROM data; valid one cycle after rom_ce
- phase_valid  out  1  output strobe, one cycle per voice
- phase_voice  out  VIDX_W  voice index of phase_out
- phase_out  out  OUT_W  acc[ACC_W-1 -: OUT_W]
- gate_out  out  1  gate of phase_voice as latched at issue
- busy  out  1  sweep in progress
- overrun  out  1  sticky flag: sample_tick arrived while busy

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All accumulators, notes and gates cleared to 0.
  - FSM returns to IDLE.
  - All outputs 0, including overrun.
  - Reset mid-sweep aborts the sweep immediately; no partial phase_valid follows.
- FSM states:
  - IDLE: sample_tick=1 sets v=0 and moves to RUN.
  - RUN: issues voice v. Drives rom_ce=1 and rom_a=note[v], and latches v and gate[v] into the issue stage. Then v increments. After issuing v=VOICES-1, moves to DRAIN.
  - DRAIN: rom_ce=0, completes the last accumulate, returns to IDLE.
- Pipeline: each cycle after an issue of voice i is the accumulate cycle for voice i.
  - If the latched gate=1: acc[i] <= acc[i] + zero-extend(rom_d), modulo 2^ACC_W; wrap-around is silent.
  - If the latched gate=0: acc[i] is held.
  - phase_valid=1, phase_voice=i, gate_out=latched gate, and phase_out=the updated value (the held value when gate=0) are all registered. They appear the cycle after the accumulate cycle.
- Timing:
  - A sweep occupies VOICES+1 cycles in RUN/DRAIN.
  - The first phase_valid appears 3 cycles after the sample_tick cycle.
  - phase_valid strobes are back-to-back, voices 0..VOICES-1 in order.
- busy is 1 in RUN and DRAIN, and 0 in IDLE.
- sample_tick while busy is ignored (the sweep is not restarted) and sets overrun=1. overrun is cleared only by reset.
- sample_tick in the DRAIN cycle also counts as busy.
- rom_ce=0 and rom_a holds its last value whenever not in RUN.
- Note table:
  - note_we writes note[note_voice] and gate[note_voice] at the clock edge; writes are accepted in any state.
  - A write to voice v in the same cycle v is issued: the issue uses the old note and gate; the new values apply from the next sweep.
- A gate 1->0 transition freezes the phase; a 0->1 transition resumes from the frozen phase.

Optional Feature:
- Macro: NCO_PHASE_RESET_ON_NOTE_EN.
- Defined: a note_we with note_gate=1 writing a voice whose stored gate is 0 also clears acc[note_voice] to 0 at the same edge. This gives a deterministic start phase.
  - If that voice is in its accumulate cycle at the same edge, the clear wins.
- Not defined: note writes never touch accumulators.

Test Plan:
- Reset, then a single sample_tick with all gates 0 -> rom_ce high for 8 cycles with rom_a=0; 8 phase_valid strobes, voices 0..7, phase_out=0, gate_out=0; busy low after 9 cycles.
- Write voice 2 note 69, gate 1; ROM model returns 901 for address 69; 3 sample ticks -> voice 2 phase_out = (3*901)>>8 = 0x000A; acc[2]=2703; all other voices 0.
- Voice 0 note 127 (step 25690), gate 1, with acc preloaded via 653 ticks -> acc wraps mod 2^24; after tick 654, phase_out equals (654*25690 mod 16777216)>>8.
- sample_tick asserted again 4 cycles into a sweep -> sweep continues unchanged, overrun=1 and stays 1; the next tick in IDLE runs normally.
- note_we for voice 3 in the cycle voice 3 is issued (old note 60, new 72) -> this sweep adds the step for 60 (536); the next sweep adds the step for 72 (1072).
- rst_n pulsed low mid-sweep -> outputs go to 0 asynchronously, no further phase_valid; with NCO_PHASE_RESET_ON_NOTE_EN, gate 0->1 rewrite of a voice with acc=5000 -> acc=0, and the next phase_out after one tick = step>>8.

Source files
------------

// File: rtl/nco_voice_acc.sv
// Time-multiplexed phase accumulator: one acc per voice, advanced by the ROM step on each sample tick.
// Latency: first phase_valid 3 cycles after sample_tick; VOICES back-to-back strobes; sweep holds busy VOICES+1 cycles.
// No backpressure: ticks arriving while busy are dropped and flagged via sticky overrun.
// Optional build macro NCO_PHASE_RESET_ON_NOTE_EN: gate 0->1 note write clears that voice's accumulator.

module nco_voice_acc #(
  parameter int VOICES = 8,
  parameter int VIDX_W = 3,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              note_we,
  input  logic [VIDX_W-1:0] note_voice,
  input  logic [6:0]        note_num,
  input  logic              note_gate,
  output logic              rom_ce,
  output logic [6:0]        rom_a,
  input  logic [15:0]       rom_d,
  output logic              phase_valid,
  output logic [VIDX_W-1:0] phase_voice,
  output logic [OUT_W-1:0]  phase_out,
  output logic              gate_out,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // sweep voice counter
  logic [VIDX_W-1:0] vidx, vidx_nxt;
  logic              last_voice;
  logic              issue;

  // per-voice note/gate table and accumulators
  logic [6:0]        note_tbl [VOICES];
  logic [VOICES-1:0] gate_tbl;
  logic [ACC_W-1:0]  acc      [VOICES];

  // issue stage: voice whose ROM read is in flight
  logic              iss_vld;
  logic [VIDX_W-1:0] iss_voice;
  logic              iss_gate;

  // accumulate-cycle datapath
  logic [ACC_W-1:0]  acc_sel;
  logic [ACC_W-1:0]  acc_new;

  logic [6:0]        rom_a_q;
  logic              ovr_q;

`ifdef NCO_PHASE_RESET_ON_NOTE_EN
  logic              phase_clr;
`endif

  assign last_voice = (vidx == VIDX_W'(VOICES - 1));

  // FSM state and sweep counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      vidx  <= '0;
    end else begin
      state <= state_nxt;
      vidx  <= vidx_nxt;
    end
  end

  // FSM next state: IDLE waits for a tick, RUN issues one voice per cycle, DRAIN finishes the last accumulate
  always_comb begin
    state_nxt = state;
    vidx_nxt  = vidx;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample_tick) begin
          state_nxt = ST_RUN;
          vidx_nxt  = '0;
        end
      end
      ST_RUN: begin
        issue    = 1'b1;
        vidx_nxt = vidx + VIDX_W'(1);
        if (last_voice) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ROM address follows the issuing voice's note and holds outside RUN
  assign rom_ce  = issue;
  assign rom_a   = issue ? note_tbl[vidx] : rom_a_q;
  assign busy    = (state != ST_IDLE);
  assign overrun = ovr_q;

  // last driven ROM address, so rom_a stays stable between sweeps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_a_q <= '0;
    end else if (issue) begin
      rom_a_q <= note_tbl[vidx];
    end
  end

  // sticky overrun: any tick seen while a sweep (including DRAIN) is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else if (sample_tick && busy) begin
      ovr_q <= 1'b1;
    end
  end

  // issue stage: capture voice and gate at issue so table writes in that cycle only affect the next sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld   <= 1'b0;
      iss_voice <= '0;
      iss_gate  <= 1'b0;
    end else begin
      iss_vld <= issue;
      if (issue) begin
        iss_voice <= vidx;
        iss_gate  <= gate_tbl[vidx];
      end
    end
  end

  // note/gate table write port, accepted in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        note_tbl[i] <= '0;
      end
      gate_tbl <= '0;
    end else if (note_we) begin
      note_tbl[note_voice] <= note_num;
      gate_tbl[note_voice] <= note_gate;
    end
  end

  // step is zero-extended; a released voice keeps its phase frozen
  always_comb begin
    acc_sel = acc[iss_voice];
    acc_new = acc_sel;
    if (iss_gate) begin
      acc_new = acc_sel + {{(ACC_W-16){1'b0}}, rom_d};
    end
  end

`ifdef NCO_PHASE_RESET_ON_NOTE_EN
  assign phase_clr = note_we && note_gate && !gate_tbl[note_voice];
`endif

  // accumulator bank: one voice updated per accumulate cycle; a note-on clear (if built in) takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (iss_vld && (iss_voice == VIDX_W'(i))) begin
          acc[i] <= acc_new;
        end
`ifdef NCO_PHASE_RESET_ON_NOTE_EN
        if (phase_clr && (note_voice == VIDX_W'(i))) begin
          acc[i] <= '0;
        end
`endif
      end
    end
  end

  // registered output stream, one strobe per voice the cycle after its accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_valid <= 1'b0;
      phase_voice <= '0;
      phase_out   <= '0;
      gate_out    <= 1'b0;
    end else begin
      phase_valid <= iss_vld;
      if (iss_vld) begin
        phase_voice <= iss_voice;
        phase_out   <= acc_new[ACC_W-1 -: OUT_W];
        gate_out    <= iss_gate;
      end
    end
  end

endmodule

// File: tb/tb_nco_voice_acc.sv
module tb_nco_voice_acc;
  localparam int VOICES = 8;
  localparam int VIDX_W = 3;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_tick = 1'b0;
  logic              note_we = 1'b0;
  logic [VIDX_W-1:0] note_voice = '0;
  logic [6:0]        note_num = '0;
  logic              note_gate = 1'b0;
  logic [15:0]       rom_d = '0;
  logic              rom_ce;
  logic [6:0]        rom_a;
  logic              phase_valid;
  logic [VIDX_W-1:0] phase_voice;
  logic [OUT_W-1:0]  phase_out;
  logic              gate_out;
  logic              busy;
  logic              overrun;

  nco_voice_acc #(.VOICES(VOICES), .VIDX_W(VIDX_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .note_we(note_we), .note_voice(note_voice), .note_num(note_num), .note_gate(note_gate),
    .rom_ce(rom_ce), .rom_a(rom_a), .rom_d(rom_d),
    .phase_valid(phase_valid), .phase_voice(phase_voice), .phase_out(phase_out),
    .gate_out(gate_out), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // step ROM contents: known steps for the notes used, filler elsewhere
  function automatic logic [15:0] step(input logic [6:0] a);
    case (a)
      7'd60:   return 16'd536;
      7'd69:   return 16'd901;
      7'd72:   return 16'd1072;
      7'd127:  return 16'd25690;
      default: return 16'(a) * 16'd13 + 16'd5;
    endcase
  endfunction

  // synchronous ROM: data one cycle after rom_ce
  always @(posedge clk) begin
    if (rom_ce) rom_d <= step(rom_a);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int               due;
    logic [VIDX_W-1:0] voice;
    logic             gate;
    logic [OUT_W-1:0] phase;
  } exp_t;

  logic [ACC_W-1:0] m_acc  [VOICES];
  logic [6:0]       m_note [VOICES];
  logic             m_gate [VOICES];
  logic [6:0]       m_last_a;
  logic             m_ovr;
  int               cyc;
  int               t0;
  bit               act;
  exp_t             q[$];
  logic [OUT_W-1:0] last_phase [VOICES];
  int               n_valid = 0;
  int               n_ce = 0;
  int               n_busy = 0;

  // timeline model: a tick accepted in cycle t0 issues voice i in cycle t0+1+i,
  // whose phase is due in cycle t0+3+i; the sweep is busy in cycles t0+1..t0+VOICES+1
  initial begin
    int   k;
    int   i;
    bit   bsy;
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int v = 0; v < VOICES; v++) begin
          m_acc[v] = '0; m_note[v] = '0; m_gate[v] = 1'b0;
        end
        m_last_a = '0; m_ovr = 1'b0; cyc = 0; t0 = 0; act = 1'b0;
        q.delete();
      end else begin
        cyc = cyc + 1;
        k   = cyc;
        bsy = act && (k > t0) && (k <= t0 + VOICES + 1);
        if (act && (k > t0) && (k <= t0 + VOICES)) begin
          i = k - t0 - 1;
          if (m_gate[i]) m_acc[i] = m_acc[i] + ACC_W'(step(m_note[i]));
          m_last_a = m_note[i];
          e.due   = k + 2;
          e.voice = VIDX_W'(i);
          e.gate  = m_gate[i];
          e.phase = m_acc[i][ACC_W-1 -: OUT_W];
          q.push_back(e);
        end
        if (sample_tick) begin
          if (bsy) m_ovr = 1'b1;
          else begin t0 = k; act = 1'b1; end
        end
        if (note_we) begin
`ifdef NCO_PHASE_RESET_ON_NOTE_EN
          if (note_gate && !m_gate[note_voice]) m_acc[note_voice] = '0;
`endif
          m_note[note_voice] = note_num;
          m_gate[note_voice] = note_gate;
        end
      end
    end
  end

  // compare process: every cycle, on the falling edge
  initial begin
    int   c;
    bit   exp_busy;
    bit   exp_ce;
    logic [6:0] exp_a;
    exp_t e;
    for (int v = 0; v < VOICES; v++) last_phase[v] = '0;
    forever begin
      @(negedge clk);
      c        = cyc + 1;
      exp_busy = act && (c > t0) && (c <= t0 + VOICES + 1);
      exp_ce   = act && (c > t0) && (c <= t0 + VOICES);
      exp_a    = exp_ce ? m_note[c - t0 - 1] : m_last_a;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("rom_ce", 32'(rom_ce), 32'(exp_ce));
      chk("rom_a", 32'(rom_a), 32'(exp_a));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (q.size() > 0 && q[0].due == c) begin
        e = q.pop_front();
        chk("phase_valid", 32'(phase_valid), 32'd1);
        chk("phase_voice", 32'(phase_voice), 32'(e.voice));
        chk("gate_out", 32'(gate_out), 32'(e.gate));
        chk("phase_out", 32'(phase_out), 32'(e.phase));
        last_phase[e.voice] = phase_out;
      end else begin
        chk("phase_valid_idle", 32'(phase_valid), 32'd0);
      end
      if (phase_valid) n_valid++;
      if (rom_ce) n_ce++;
      if (busy) n_busy++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
  endtask

  task automatic sweep();
    tick();
    repeat (11) @(negedge clk);
  endtask

  task automatic wr(input int v, input int n, input bit g);
    @(negedge clk);
    note_we = 1'b1; note_voice = VIDX_W'(v); note_num = 7'(n); note_gate = g;
    @(negedge clk);
    note_we = 1'b0;
  endtask

  initial begin
    int sv, sc, sb;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_phase_valid", 32'(phase_valid), 32'd0);
    chk("rst_rom_ce", 32'(rom_ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_phase_out", 32'(phase_out), 32'd0);
    chk("rst_rom_a", 32'(rom_a), 32'd0);
    rst_n = 1'b1;

    // one sweep with all gates off
    sv = n_valid; sc = n_ce; sb = n_busy;
    sweep();
    chk("sweep_valid_count", 32'(n_valid - sv), 32'd8);
    chk("sweep_ce_count", 32'(n_ce - sc), 32'd8);
    chk("sweep_busy_count", 32'(n_busy - sb), 32'd9);

    // voice 2, note 69, three ticks
    wr(2, 69, 1'b1);
    repeat (3) sweep();
    chk("v2_phase", 32'(last_phase[2]), 32'h000A);
    chk("v2_model_acc", 32'(m_acc[2]), 32'd2703);
    chk("v5_phase", 32'(last_phase[5]), 32'd0);

    // voice 0, note 127, wrap after 654 ticks
    wr(0, 127, 1'b1);
    repeat (654) sweep();
    chk("v0_wrap_phase", 32'(last_phase[0]), 32'h005D);
    chk("v0_wrap_model_acc", 32'(m_acc[0]), 32'd24044);

    // tick four cycles into a sweep
    chk("ovr_before", 32'(overrun), 32'd0);
    tick();
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    repeat (10) @(negedge clk);
    chk("ovr_set", 32'(overrun), 32'd1);
    sweep();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // note write to voice 3 in the cycle voice 3 is issued
    wr(3, 60, 1'b1);
    tick();
    repeat (3) @(negedge clk);
    note_we = 1'b1; note_voice = 3'd3; note_num = 7'd72; note_gate = 1'b1;
    @(negedge clk); note_we = 1'b0;
    repeat (10) @(negedge clk);
    chk("v3_old_note_acc", 32'(m_acc[3]), 32'd536);
    chk("v3_old_note_phase", 32'(last_phase[3]), 32'd2);
    sweep();
    chk("v3_new_note_acc", 32'(m_acc[3]), 32'd1608);
    chk("v3_new_note_phase", 32'(last_phase[3]), 32'd6);

    // asynchronous reset in the middle of a sweep
    tick();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(phase_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ce", 32'(rom_ce), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_phase", 32'(phase_out), 32'd0);
    sv = n_valid;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_valid_after_rst", 32'(n_valid - sv), 32'd0);

    // tick in the DRAIN cycle counts as busy
    tick();
    repeat (8) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    repeat (10) @(negedge clk);
    chk("drain_ovr", 32'(overrun), 32'd1);

    // gate release freezes, gate re-press resumes (or restarts from 0 if built in)
    wr(4, 60, 1'b1);
    repeat (2) sweep();
    chk("v4_two_ticks", 32'(m_acc[4]), 32'd1072);
    wr(4, 60, 1'b0);
    sweep();
    chk("v4_frozen", 32'(last_phase[4]), 32'd4);
    wr(4, 69, 1'b1);
    sweep();
`ifdef NCO_PHASE_RESET_ON_NOTE_EN
    chk("v4_restart_phase", 32'(last_phase[4]), 32'd3);
`else
    chk("v4_resume_phase", 32'(last_phase[4]), 32'd7);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
